// File: rtl/clkmon_pkg.sv
// rtl/clkmon_pkg.sv - shared types and defaults for the clock activity monitor
//
// Holds the monitor FSM state encoding and the default widths/limits used
// as parameter defaults by clk_activity_monitor. No ports.
package clkmon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } mon_state_t;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_WIN_W     = 8;
  localparam int DEF_STUCK_LIM = 64;

endpackage

// File: rtl/clk_sync_edge.sv
// rtl/clk_sync_edge.sv - two-flop synchronizer with rising-edge detect
//
// Brings the asynchronous monitored clock A into the CLK domain and flags
// each rising edge as a single-cycle pulse.
//   CLK        in   sampling clock
//   R          in   asynchronous active-high reset
//   A          in   monitored signal, asynchronous to CLK
//   edge_pulse out  high for one CLK cycle per synchronized rising edge of A
module clk_sync_edge (
  input  logic CLK,
  input  logic R,
  input  logic A,
  output logic edge_pulse
);

  logic a_meta;
  logic a_sync;
  logic a_hist;

  // History clears with the synchronizer so an A already high at reset
  // release still produces exactly one pulse once it propagates through.
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      a_meta <= 1'b0;
      a_sync <= 1'b0;
      a_hist <= 1'b0;
    end else begin
      a_meta <= A;
      a_sync <= a_meta;
      a_hist <= a_sync;
    end
  end

  assign edge_pulse = a_sync & ~a_hist;

endmodule

// File: rtl/clk_activity_monitor.sv
// rtl/clk_activity_monitor.sv - windowed edge counter and stuck detector for a monitored clock
//
// Counts synchronized rising edges of A over a window of WIN CLK cycles,
// reports the count with range flags, and flags A as stuck after STUCK_LIM
// enabled cycles without an edge.
//   CLK      in   sole clock
//   R        in   asynchronous active-high reset
//   A        in   monitored clock, asynchronous
//   EN       in   monitor enable
//   WIN      in   window length in CLK cycles (0 behaves as 1), sampled at window start
//   MIN_CNT  in   lowest acceptable count
//   MAX_CNT  in   highest acceptable count
//   CNT      out  count of last completed window (saturating)
//   DONE     out  one-cycle pulse when CNT/LOW/HIGH update
//   LOW      out  last count below MIN_CNT
//   HIGH     out  last count above MAX_CNT
//   STUCK    out  no edge for STUCK_LIM or more consecutive enabled cycles
module clk_activity_monitor
  import clkmon_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int WIN_W     = DEF_WIN_W,
  parameter int STUCK_LIM = DEF_STUCK_LIM
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             A,
  input  logic             EN,
  input  logic [WIN_W-1:0] WIN,
  input  logic [CNT_W-1:0] MIN_CNT,
  input  logic [CNT_W-1:0] MAX_CNT,
  output logic [CNT_W-1:0] CNT,
  output logic             DONE,
  output logic             LOW,
  output logic             HIGH,
  output logic             STUCK
);

  localparam int               STK_W   = $clog2(STUCK_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [STK_W-1:0] STK_LIM = STK_W'(STUCK_LIM);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  logic             edge_pulse;
  mon_state_t       state;
  logic [WIN_W-1:0] win_tmr;
  logic [CNT_W-1:0] edge_cnt;
  logic [STK_W-1:0] stuck_cnt;

  logic [WIN_W-1:0] win_load;
  logic [CNT_W-1:0] edge_cnt_inc;
  logic [CNT_W-1:0] first_cnt;
  logic [STK_W-1:0] stuck_next;

  clk_sync_edge u_sync_edge (
    .CLK        (CLK),
    .R          (R),
    .A          (A),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    win_load     = (WIN == '0) ? WIN_ONE : WIN;
    edge_cnt_inc = (edge_pulse && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    // A pulse on the cycle a window is opened belongs to that new window.
    first_cnt    = edge_pulse ? CNT_W'(1) : '0;

    if (!EN || edge_pulse) begin
      stuck_next = '0;
    end else if (stuck_cnt == STK_LIM) begin
      stuck_next = stuck_cnt;
    end else begin
      stuck_next = stuck_cnt + STK_W'(1);
    end
  end

  // Window FSM. The timer counts down COUNT cycles; the cycle it reads one
  // is the last COUNT cycle, so a window spans exactly win_load COUNT cycles.
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state    <= IDLE;
      win_tmr  <= '0;
      edge_cnt <= '0;
      CNT      <= '0;
      DONE     <= 1'b0;
      LOW      <= 1'b0;
      HIGH     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (EN) begin
            state    <= COUNT;
            win_tmr  <= win_load;
            edge_cnt <= first_cnt;
          end
        end
        COUNT: begin
          if (!EN) begin
            // Abandoned window: reported outputs are left untouched.
            state <= IDLE;
          end else begin
            edge_cnt <= edge_cnt_inc;
            win_tmr  <= win_tmr - WIN_ONE;
            if (win_tmr == WIN_ONE) begin
              state <= REPORT;
            end
          end
        end
        REPORT: begin
          // The report always completes, even if EN has just dropped.
          CNT  <= edge_cnt;
          LOW  <= (edge_cnt < MIN_CNT);
          HIGH <= (edge_cnt > MAX_CNT);
          DONE <= 1'b1;
          if (EN) begin
            state    <= COUNT;
            win_tmr  <= win_load;
            edge_cnt <= first_cnt;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stuck detection runs independently of the window FSM.
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      stuck_cnt <= '0;
      STUCK     <= 1'b0;
    end else begin
      stuck_cnt <= stuck_next;
      STUCK     <= (stuck_next == STK_LIM);
    end
  end

endmodule

// File: tb/tb_clk_activity_monitor.sv
// tb/tb_clk_activity_monitor.sv - scoreboard bench for clk_activity_monitor
module tb_clk_activity_monitor;

  localparam int CNT_W     = 4;
  localparam int WIN_W     = 8;
  localparam int STUCK_LIM = 64;
  localparam int CNT_SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             r;
  logic             a;
  logic             en;
  logic [WIN_W-1:0] win;
  logic [CNT_W-1:0] min_cnt;
  logic [CNT_W-1:0] max_cnt;
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             low;
  logic             high;
  logic             stuck;

  always #5 clk = ~clk;

  clk_activity_monitor #(
    .CNT_W     (CNT_W),
    .WIN_W     (WIN_W),
    .STUCK_LIM (STUCK_LIM)
  ) dut (
    .CLK     (clk),
    .R       (r),
    .A       (a),
    .EN      (en),
    .WIN     (win),
    .MIN_CNT (min_cnt),
    .MAX_CNT (max_cnt),
    .CNT     (cnt),
    .DONE    (done),
    .LOW     (low),
    .HIGH    (high),
    .STUCK   (stuck)
  );

  typedef struct {
    int cnt;
    bit low;
    bit high;
    int cyc;
  } rpt_t;

  rpt_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   phase    = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endfunction

  // Reference model: A samples per CLK edge, an edge is seen two samples
  // late, windows are tracked as (remaining slots, raw edge total).
  bit a_q[$];
  bit in_win;
  bit rpt_due;
  int remaining;
  int raw_edges;
  int quiet_run;
  int held_cnt;
  bit held_low;
  bit held_high;

  function automatic void open_window(bit p);
    in_win    = 1'b1;
    remaining = (win == 0) ? 1 : int'(win);
    raw_edges = p ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    bit p;
    int c;
    cyc++;
    if (r) begin
      a_q       = '{1'b0, 1'b0, 1'b0};
      in_win    = 1'b0;
      rpt_due   = 1'b0;
      remaining = 0;
      raw_edges = 0;
      quiet_run = 0;
      held_cnt  = 0;
      held_low  = 1'b0;
      held_high = 1'b0;
      exp_q.delete();
    end else begin
      p = a_q[1] && !a_q[2];
      a_q.push_front(a);
      void'(a_q.pop_back());
      quiet_run = (en && !p) ? quiet_run + 1 : 0;
      if (rpt_due) begin
        rpt_due   = 1'b0;
        c         = (raw_edges > CNT_SAT) ? CNT_SAT : raw_edges;
        held_cnt  = c;
        held_low  = (c < int'(min_cnt));
        held_high = (c > int'(max_cnt));
        exp_q.push_back('{c, held_low, held_high, cyc});
        if (en) open_window(p);
      end else if (in_win) begin
        if (!en) begin
          in_win = 1'b0;
        end else begin
          raw_edges += p ? 1 : 0;
          remaining--;
          if (remaining == 0) begin
            in_win  = 1'b0;
            rpt_due = 1'b1;
          end
        end
      end else if (en) begin
        open_window(p);
      end
    end
  end

  // Monitor: pops an expected report whenever one is due this cycle.
  always @(negedge clk) begin
    rpt_t e;
    bit   exp_done;
    exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("done", int'(done), int'(exp_done));
    if (exp_done) begin
      e = exp_q.pop_front();
      if (done) begin
        chk("rpt_cnt", int'(cnt), e.cnt);
        chk("rpt_low", int'(low), int'(e.low));
        chk("rpt_high", int'(high), int'(e.high));
      end
    end
    chk("cnt_hold", int'(cnt), held_cnt);
    chk("low_hold", int'(low), int'(held_low));
    chk("high_hold", int'(high), int'(held_high));
    chk("stuck", int'(stuck), (quiet_run >= STUCK_LIM) ? 1 : 0);
  end

  // per > 0: square wave of that period; per < 0: random A; per == 0: hold.
  task automatic drive(int n, int per);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (per > 0) begin
        a = ((phase % per) < (per / 2));
        phase++;
      end else if (per < 0) begin
        a = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_cnt"}, int'(cnt), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_low"}, int'(low), 0);
    chk({tag, "_high"}, int'(high), 0);
    chk({tag, "_stuck"}, int'(stuck), 0);
  endtask

  initial begin
    int per;
    r       = 1'b1;
    a       = 1'b0;
    en      = 1'b0;
    win     = '0;
    min_cnt = '0;
    max_cnt = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    r = 1'b0;

    // Nominal clock: period 8, 64-cycle windows
    win = 8'd64; min_cnt = 4'd7; max_cnt = 4'd9; en = 1'b1;
    drive(210, 8);

    // Fast clock saturates the counter
    win = 8'd255; min_cnt = 4'd0; max_cnt = 4'd10;
    drive(600, 2);

    // Dead clock, then a single rise
    a = 1'b0; win = 8'd100; min_cnt = 4'd1; max_cnt = 4'd9;
    drive(150, 0);
    a = 1'b1;
    drive(10, 0);

    // Enable dropped 30 cycles into a window
    en = 1'b0;
    drive(5, 0);
    en = 1'b1; win = 8'd64; min_cnt = 4'd7;
    drive(30, 8);
    en = 1'b0;
    drive(10, 8);

    // Reset in the middle of a window with A toggling
    en = 1'b1;
    drive(40, 4);
    #2 r = 1'b1;
    #1 check_all_zero("async_reset");
    drive(3, 4);
    r = 1'b0;
    drive(140, 4);

    // Zero-length window
    win = '0; min_cnt = 4'd0; max_cnt = 4'd1;
    drive(40, 4);

    // Randomized operation
    for (int k = 0; k < 40; k++) begin
      win     = WIN_W'($urandom_range(0, 20));
      min_cnt = CNT_W'($urandom_range(0, CNT_SAT));
      max_cnt = CNT_W'($urandom_range(0, CNT_SAT));
      en      = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0:       per = -1;
        1:       per = 0;
        default: per = 2 * int'($urandom_range(1, 5));
      endcase
      drive(int'($urandom_range(5, 40)), per);
    end

    en = 1'b0;
    drive(10, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
